// File: rtl/core_block_receiver.sv
// Core-side block receiver: latches block metadata, launches the thread pipeline,
// waits for RET and pipeline drain, then holds core_done until core_reset.
// Optional: define CORE_BLOCK_PERF_EN to add the block_cycles performance counter output.
module core_block_receiver #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int ID_WIDTH          = 8,
    localparam int CNT_W            = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  core_reset,
    input  logic                                  core_start,
    input  logic [ID_WIDTH-1:0]                   core_block_id,
    input  logic [CNT_W-1:0]                      core_thread_count,
    output logic                                  core_done,
    output logic                                  launch,
    output logic [THREADS_PER_BLOCK-1:0]          thread_enable,
    output logic [THREADS_PER_BLOCK*ID_WIDTH-1:0] thread_id,
`ifdef CORE_BLOCK_PERF_EN
    output logic [15:0]                           block_cycles,
`endif
    input  logic                                  exec_ret,
    input  logic                                  threads_idle
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] cnt);
        if (32'(cnt) > THREADS_PER_BLOCK)
            return CNT_W'(THREADS_PER_BLOCK);
        return cnt;
    endfunction

    function automatic logic [THREADS_PER_BLOCK-1:0] enable_mask(input logic [CNT_W-1:0] cnt);
        logic [THREADS_PER_BLOCK-1:0] m;
        for (int i = 0; i < THREADS_PER_BLOCK; i++)
            m[i] = (i < 32'(cnt));
        return m;
    endfunction

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (core_start) begin
                    id_d    = core_block_id;
                    cnt_d   = clamp_count(core_thread_count);
                    state_d = S_LATCH;
                end
            end
            // An empty block skips execution entirely and reports done at once.
            S_LATCH: state_d = (cnt_q == '0) ? S_DONE : S_RUN;
            S_RUN:   if (exec_ret) state_d = S_DRAIN;
            S_DRAIN: if (threads_idle) state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || core_reset) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        core_done     = (state_q == S_DONE);
        launch        = (state_q == S_LATCH) && (cnt_q != '0);
        thread_enable = '0;
        thread_id     = '0;
        if (state_q == S_LATCH || state_q == S_RUN || state_q == S_DRAIN)
            thread_enable = enable_mask(cnt_q);
        // Global ids stay visible through DONE and wrap modulo 2^ID_WIDTH.
        if (state_q != S_IDLE) begin
            for (int i = 0; i < THREADS_PER_BLOCK; i++)
                thread_id[i*ID_WIDTH +: ID_WIDTH] =
                    ID_WIDTH'(32'(id_q) * 32'(THREADS_PER_BLOCK) + 32'(i));
        end
    end

`ifdef CORE_BLOCK_PERF_EN
    logic [15:0] cyc_q, cyc_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        cyc_d = cyc_q;
        if (state_q == S_IDLE && core_start)
            cyc_d = '0;
        else if (state_q == S_LATCH || state_q == S_RUN || state_q == S_DRAIN)
            cyc_d = sat_inc(cyc_q);
    end

    always_ff @(posedge clk) begin
        if (reset || core_reset)
            cyc_q <= '0;
        else
            cyc_q <= cyc_d;
    end

    assign block_cycles = cyc_q;
`endif

endmodule
